// File: rtl/gcn_pkg.sv
// Types shared by the GCN transformation control path.
package gcn_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WEIGHT  = 2'd1,
    S_FEATURE = 2'd2,
    S_DONE    = 2'd3
  } read_seq_state_t;

endpackage

// File: rtl/read_sequencer_wrap_counter.sv
// Up-counter modulo MODULUS with enable, sync clear and terminal flag.
// Clear has priority over enable; enabling at terminal count wraps to 0.
module wrap_counter #(
  parameter int MODULUS = 4,
  parameter int WIDTH   = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  assign terminal = (count == WIDTH'(MODULUS - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= terminal ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/read_sequencer.sv
// Walks weight columns: one weight read then FEATURE_ROWS feature reads each.
// data_* outputs lag the read strobes by one cycle; stall freezes the walk.
module read_sequencer
  import gcn_pkg::*;
#(
  parameter int WEIGHT_COLS           = 3,
  parameter int FEATURE_ROWS          = 6,
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stall,
  output logic                             read_feature_or_weight,
  output logic [COUNTER_FEATURE_WIDTH-1:0] feature_count,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_count,
  output logic                             read_enable,
  output logic                             data_valid,
  output logic                             data_is_feature,
  output logic [COUNTER_FEATURE_WIDTH-1:0] data_row,
  output logic                             column_done,
  output logic                             busy,
  output logic                             done
);

  read_seq_state_t state, next_state;
  logic f_en, f_clr, f_term;
  logic w_en, w_clr, w_term;

  wrap_counter #(.MODULUS(FEATURE_ROWS), .WIDTH(COUNTER_FEATURE_WIDTH)) u_feature_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (f_clr),
    .enable   (f_en),
    .count    (feature_count),
    .terminal (f_term)
  );

  wrap_counter #(.MODULUS(WEIGHT_COLS), .WIDTH(COUNTER_WEIGHT_WIDTH)) u_weight_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clr),
    .enable   (w_en),
    .count    (weight_count),
    .terminal (w_term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state             = state;
    read_feature_or_weight = 1'b0;
    read_enable            = 1'b0;
    busy                   = 1'b1;
    done                   = 1'b0;
    f_en                   = 1'b0;
    f_clr                  = 1'b0;
    w_en                   = 1'b0;
    w_clr                  = 1'b0;
    case (state)
      S_IDLE: begin
        busy  = 1'b0;
        f_clr = 1'b1;
        w_clr = 1'b1;
        if (start) next_state = S_WEIGHT;
      end
      S_WEIGHT: begin
        read_enable = !stall;
        if (!stall) begin
          f_clr      = 1'b1;
          next_state = S_FEATURE;
        end
      end
      S_FEATURE: begin
        read_feature_or_weight = 1'b1;
        read_enable            = !stall;
        if (!stall) begin
          if (!f_term) begin
            f_en = 1'b1;
          end else if (!w_term) begin
            // feature counter wraps to 0 while the column advances
            f_en       = 1'b1;
            w_en       = 1'b1;
            next_state = S_WEIGHT;
          end else begin
            next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        f_clr      = 1'b1;
        w_clr      = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Aligned with the 1-cycle synchronous memory read.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid      <= 1'b0;
      data_is_feature <= 1'b0;
      data_row        <= '0;
      column_done     <= 1'b0;
    end else begin
      data_valid      <= read_enable;
      data_is_feature <= read_feature_or_weight;
      data_row        <= feature_count;
      column_done     <= read_enable & read_feature_or_weight & f_term;
    end
  end

endmodule
